// File: rtl/core_wb_arbiter.sv
// Two-requester arbiter (IFU = requester 0, MAU = requester 1) sharing one pipelined Wishbone master port.
// A grant spans a whole cyc envelope and is held until every issued transfer has been answered.
module core_wb_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4,
    parameter int FAIR      = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW/8-1:0] m0_sel,
    input  logic [DW-1:0]   m0_dat,
    output logic            m0_stall,
    output logic            m0_ack,
    output logic            m0_err,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW/8-1:0] m1_sel,
    input  logic [DW-1:0]   m1_dat,
    output logic            m1_stall,
    output logic            m1_ack,
    output logic            m1_err,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW/8-1:0] s_sel,
    output logic [DW-1:0]   s_dat,
    input  logic            s_stall,
    input  logic            s_ack,
    input  logic            s_err,
    input  logic [DW-1:0]   dat_in,
    output logic [1:0]      grant
);

    localparam int            CW    = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] w_outst_nxt;
    logic          r_last;
    logic          w_own_cyc;
    logic          w_full;
    logic          w_inc;
    logic          w_rsp;

    // Read data reaches both requesters directly; the arbiter never touches it.
    logic w_unused;
    assign w_unused = ^dat_in;

    assign w_full = (r_outst == MAX_C);
    assign w_inc  = s_stb && !s_stall;
    assign w_rsp  = s_ack || s_err;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_own_cyc = 1'b0;
        case (r_state)
            GNT0:    w_own_cyc = m0_cyc;
            GNT1:    w_own_cyc = m1_cyc;
            default: w_own_cyc = 1'b0;
        endcase
    end

    // A stray response with nothing in flight is forwarded but never underflows the count.
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_inc && !w_rsp)
            w_outst_nxt = r_outst + 1'b1;
        else if (w_rsp && !w_inc && (r_outst != '0))
            w_outst_nxt = r_outst - 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    if (FAIR != 0)
                        w_state_nxt = r_last ? GNT0 : GNT1;
                    else
                        w_state_nxt = GNT1;
                end else if (m0_cyc) begin
                    w_state_nxt = GNT0;
                end else if (m1_cyc) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!w_own_cyc && (w_outst_nxt == '0))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat    = '0;
        m0_stall = 1'b1;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_stall = 1'b1;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        grant    = 2'b00;
        case (r_state)
            GNT0: begin
                s_cyc    = m0_cyc || (r_outst != '0);
                s_stb    = m0_stb && m0_cyc && !w_full;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_dat    = m0_dat;
                m0_stall = s_stall || w_full;
                m0_ack   = s_ack;
                m0_err   = s_err;
                grant    = 2'b01;
            end
            GNT1: begin
                s_cyc    = m1_cyc || (r_outst != '0);
                s_stb    = m1_stb && m1_cyc && !w_full;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_dat    = m1_dat;
                m1_stall = s_stall || w_full;
                m1_ack   = s_ack;
                m1_err   = s_err;
                grant    = 2'b10;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_outst <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_outst <= w_outst_nxt;
            if (r_state == IDLE && w_state_nxt == GNT0)
                r_last <= 1'b0;
            else if (r_state == IDLE && w_state_nxt == GNT1)
                r_last <= 1'b1;
        end
    end

endmodule

// File: doc/core_wb_arbiter.md
Name: core_wb_arbiter

Overview:
- Two-requester arbiter sharing the core's single pipelined Wishbone master port between instruction fetch (requester 0, IFU) and the memory access unit (requester 1, MAU).
- Grants one requester a whole bus cycle (cyc envelope) and forwards its pipelined stb/stall/ack/err traffic.
- Tracks outstanding transfers so the grant never moves while responses are in flight.
- Sits between the fetch/MAU blocks and the core's external Wishbone port.

Parameters:
- AW, 32, address width.
- DW, 32, data width (sel width = DW/8).
- MAX_OUTST, 4, maximum issued-but-unacknowledged transfers per grant (≥1).
- FAIR, 1, 1 = round-robin on contention; 0 = fixed priority to MAU (requester 1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- m0_cyc, m0_stb, m0_we  in  1 each  IFU request signals
- m0_adr  in  AW  IFU address
- m0_sel  in  DW/8  IFU byte select
- m0_dat  in  DW  IFU write data
- m0_stall, m0_ack, m0_err  out  1 each  IFU responses
- m1_cyc, m1_stb, m1_we  in  1 each  MAU request signals
- m1_adr  in  AW  MAU address
- m1_sel  in  DW/8  MAU byte select
- m1_dat  in  DW  MAU write data
- m1_stall, m1_ack, m1_err  out  1 each  MAU responses
- s_cyc, s_stb, s_we  out  1 each  to external bus
- s_adr  out  AW  to external bus
- s_sel  out  DW/8  to external bus
- s_dat  out  DW  to external bus
- s_stall, s_ack, s_err  in  1 each  from external bus
- dat_in  in  DW  read data from bus; fanned out unchanged to both requesters (qualified by their ack)
- grant  out  2  one-hot current owner; 00 in IDLE

Behaviour:
- Reset (rst low, async): state IDLE, outst=0, last=0 (requester 0 served last), grant=00. All s_* outputs 0, m*_ack/m*_err 0, m*_stall 1.
- States: IDLE, GNT0, GNT1; state register only. Outputs are combinational from state plus the granted requester's inputs.
- IDLE:
  - s_cyc=s_stb=0; both m*_stall=1.
  - Only m0_cyc → GNT0; only m1_cyc → GNT1.
  - Both with FAIR=1 → grant the requester not equal to last.
  - Both with FAIR=0 → GNT1.
  - Latency: a request visible in cycle N is granted and driven onto s_* in cycle N+1.
- GNTx:
  - s_cyc = mx_cyc OR (outst≠0); s_stb = mx_stb AND mx_cyc AND (outst<MAX_OUTST).
  - s_adr/s_sel/s_we/s_dat = mx_*.
  - mx_stall = s_stall OR (outst==MAX_OUTST). The other requester's stall=1, ack=0, err=0.
  - mx_ack = s_ack; mx_err = s_err.
  - On entry, last←x.
- Outstanding counter:
  - Increment on s_stb&&!s_stall; decrement on s_ack||s_err.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTST; never underflows. A stray ack at outst=0 is passed to the owner and the counter stays 0.
- Release: GNTx → IDLE when mx_cyc==0 and outst==0, or when the counter's next value is 0 and mx_cyc==0.
  - Always via IDLE, so s_cyc is low at least one cycle between owners. No direct GNT0↔GNT1.
- Owner drops cyc with outst>0: s_cyc is held high and stb is masked until drained. Late acks/errs still route to the owner.
- s_err: counts as a response (decrement) and is forwarded. The arbiter does not abort or flush; the owner decides whether to drop cyc.
- Non-owner raising cyc mid-grant: ignored until IDLE. Its inputs have no effect on s_*.
- Reset mid-transfer: immediate return to reset values, counter cleared. Pending bus responses after reset release are ignored (outst=0, grant=00).

Test Plan:
1. Single MAU read: m1_cyc/stb, adr=0x100, sel=4'hF, we=0. Expect s_cyc/stb in the next cycle, grant=10. Slave acks 2 cycles later with dat_in=0xDEADBEEF → m1_ack=1, m0_ack=0. After m1_cyc drops: grant=00, one idle cycle.
2. Contention, FAIR=1: both requesters raise cyc together in 3 consecutive single-transfer rounds. Expect grants 10, 01, 10 (MAU first since last=0 after reset), s_cyc low one cycle between each.
3. Contention, FAIR=0: same stimulus → MAU granted every round; IFU sees stall=1 throughout.
4. Pipelining limit, MAX_OUTST=4: IFU issues 6 back-to-back stb, slave holds ack. After 4 accepted: m0_stall=1, s_stb=0. Each ack re-enables exactly one issue; the 6th acceptance occurs only after the 2nd ack.
5. Early cyc drop: IFU issues 2 transfers, drops cyc before acks. s_cyc stays 1 until the 2nd ack arrives; MAU request waiting meanwhile is granted only after the drain plus one idle cycle.
6. Error and reset: s_err on the 1st of 2 outstanding → m1_err=1, outst=1. Assert rst before the 2nd ack → all outputs at reset values the same cycle; a post-reset ack produces no m*_ack.
